// File: rtl/pipe_regfile_pkg.sv
// -----------------------------------------------------------------------------
// pipe_regfile_pkg
//   Shared definitions for the RV integer register file:
//   default data width and register count, ABI register indices, and a
//   helper that tells the register file which reset value each index takes.
// -----------------------------------------------------------------------------
package pipe_regfile_pkg;

   localparam int XLEN   = 32;
   localparam int NREG   = 32;
   localparam int REG_AW = $clog2(NREG);

   // ABI indices with special reset / read behaviour
   localparam int REG_ZERO = 0;
   localparam int REG_SP   = 2;
   localparam int REG_GP   = 3;

   // Which reset value a register takes
   typedef enum logic [1:0] {
      INIT_ZERO = 2'd0,
      INIT_SP   = 2'd1,
      INIT_GP   = 2'd2
   } init_sel_e;

   // Returns a selector rather than a value so the register file can keep
   // its own XLEN and SP/GP parameters.
   function automatic init_sel_e reg_init_sel(input int idx);
      init_sel_e sel;
      sel = INIT_ZERO;
      if (idx == REG_SP) sel = INIT_SP;
      else if (idx == REG_GP) sel = INIT_GP;
      else if (idx == REG_ZERO) sel = INIT_ZERO;
      return sel;
   endfunction

endpackage

// File: rtl/pipe_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// pipe_regfile_scoreboard
//   Pending-write tracker: one bit per register, set when an instruction
//   writing that register issues, cleared when its write-back arrives.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     i_iss_en      issue strobe
//     i_iss_rd      destination of the issuing instruction
//     i_clr_en      write-back strobe
//     i_clr_rd      write-back destination
//     o_pend        pending vector, bit 0 always 0
// -----------------------------------------------------------------------------
module pipe_regfile_scoreboard #(
   parameter  int NREG = 32,
   localparam int AW   = $clog2(NREG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_iss_en,
   input  logic [AW-1:0]   i_iss_rd,
   input  logic            i_clr_en,
   input  logic [AW-1:0]   i_clr_rd,
   output logic [NREG-1:0] o_pend
);

   logic [NREG-1:0] r_pend;
   logic [NREG-1:0] w_set;
   logic [NREG-1:0] w_clr;

   generate
      for (genvar gi = 0; gi < NREG; gi++) begin : g_dec
         if (gi == 0) begin : g_zero
            // x0 is never a real destination
            assign w_set[gi] = 1'b0;
            assign w_clr[gi] = 1'b0;
         end else begin : g_reg
            assign w_set[gi] = i_iss_en && (i_iss_rd == AW'(gi));
            assign w_clr[gi] = i_clr_en && (i_clr_rd == AW'(gi));
         end
      end
   endgenerate

   // Set is applied after clear: a same-cycle issue belongs to a newer
   // producer than the write-back, so the register stays pending.
   always_ff @(posedge clk) begin
      if (rst) r_pend <= '0;
      else     r_pend <= (r_pend & ~w_clr) | w_set;
   end

   assign o_pend = r_pend;

endmodule

// File: rtl/pipe_regfile.sv
// -----------------------------------------------------------------------------
// pipe_regfile
//   Integer register file with NRD registered read ports and one write port,
//   optional same-cycle write-to-read bypass, x0 hardwired to zero, sp/gp
//   initialised on reset, and a pending-write scoreboard for RAW detection.
//   Ports:
//     clk, rst      clock, synchronous active-high reset
//     i_rd_addr     NRD read addresses, port k at [k*AW +: AW]
//     o_rd_data     registered read data, port k at [k*XLEN +: XLEN]
//     o_rd_busy     comb: port k reads a register with an unresolved write
//     i_wr_en       write-back strobe
//     i_wr_addr     write destination
//     i_wr_data     write data
//     i_iss_en      issue strobe
//     i_iss_rd      destination of the issuing instruction
//     o_pend        scoreboard vector
// -----------------------------------------------------------------------------
module pipe_regfile
   import pipe_regfile_pkg::*;
#(
   parameter  int              XLEN    = pipe_regfile_pkg::XLEN,
   parameter  int              NREG    = pipe_regfile_pkg::NREG,
   parameter  int              NRD     = 2,
   parameter  int              BYPASS  = 1,
   parameter  logic [XLEN-1:0] SP_INIT = 32'h0000_01F4,
   parameter  logic [XLEN-1:0] GP_INIT = 32'h1000_0000,
   localparam int              AW      = $clog2(NREG)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   i_rd_addr,
   output logic [NRD*XLEN-1:0] o_rd_data,
   output logic [NRD-1:0]      o_rd_busy,
   input  logic                i_wr_en,
   input  logic [AW-1:0]       i_wr_addr,
   input  logic [XLEN-1:0]     i_wr_data,
   input  logic                i_iss_en,
   input  logic [AW-1:0]       i_iss_rd,
   output logic [NREG-1:0]     o_pend
);

   logic [XLEN-1:0] r_regs [NREG];
   logic [NREG-1:0] w_pend;
   logic            w_wr_ok;

   // Writes to x0 are dropped so storage for x0 stays at its reset zero
   assign w_wr_ok = i_wr_en && (i_wr_addr != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            case (reg_init_sel(i))
               INIT_SP: r_regs[i] <= SP_INIT;
               INIT_GP: r_regs[i] <= GP_INIT;
               default: r_regs[i] <= '0;
            endcase
         end
      end else if (w_wr_ok) begin
         r_regs[i_wr_addr] <= i_wr_data;
      end
   end

   pipe_regfile_scoreboard #(
      .NREG (NREG)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .i_iss_en (i_iss_en),
      .i_iss_rd (i_iss_rd),
      .i_clr_en (i_wr_en),
      .i_clr_rd (i_wr_addr),
      .o_pend   (w_pend)
   );

   assign o_pend = w_pend;

   generate
      for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
         logic [AW-1:0]   w_raddr;
         logic            w_match;
         logic            w_hit;
         logic [XLEN-1:0] r_data;

         assign w_raddr = i_rd_addr[gi*AW +: AW];
         assign w_match = (BYPASS != 0) && i_wr_en && (i_wr_addr == w_raddr);
         assign w_hit   = w_match && (i_wr_addr != '0);

         always_ff @(posedge clk) begin
            if (rst)                  r_data <= '0;
            else if (w_raddr == '0)   r_data <= '0;
            else if (w_hit)           r_data <= i_wr_data;
            else                      r_data <= r_regs[w_raddr];
         end

         assign o_rd_data[gi*XLEN +: XLEN] = r_data;
         // A write landing this cycle satisfies the dependency when bypassed
         assign o_rd_busy[gi] = w_pend[w_raddr] && !w_match;
      end
   endgenerate

endmodule
